// File: rtl/cam_pkg.sv
// Shared types and constants for the DVP camera-source emulator.
package cam_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } phase_e;

    localparam logic [1:0] PatBars  = 2'd0;
    localparam logic [1:0] PatCount = 2'd1;
    localparam logic [1:0] PatRamp  = 2'd2;
    localparam logic [1:0] PatCheck = 2'd3;

    localparam logic [15:0] BarWhite   = 16'hFFFF;
    localparam logic [15:0] BarYellow  = 16'hFFE0;
    localparam logic [15:0] BarCyan    = 16'h07FF;
    localparam logic [15:0] BarGreen   = 16'h07E0;
    localparam logic [15:0] BarMagenta = 16'hF81F;
    localparam logic [15:0] BarRed     = 16'hF800;
    localparam logic [15:0] BarBlue    = 16'h001F;
    localparam logic [15:0] BarBlack   = 16'h0000;

    function automatic logic [15:0] bar_colour(input logic [2:0] bar);
        logic [15:0] c;
        case (bar)
            3'd0:    c = BarWhite;
            3'd1:    c = BarYellow;
            3'd2:    c = BarCyan;
            3'd3:    c = BarGreen;
            3'd4:    c = BarMagenta;
            3'd5:    c = BarRed;
            3'd6:    c = BarBlue;
            default: c = BarBlack;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cam_pattern_pix.sv
// Combinational test-pattern generator: one RGB565 pixel from position and pattern.
module cam_pattern_pix
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 800
) (
    input  logic [15:0] x,
    input  logic [15:0] y,
    input  logic [1:0]  pat_q,
    input  logic [15:0] pix_idx,
    output logic [15:0] pix
);

    logic [2:0] bar;
    logic       unused_y;

    assign unused_y = ^{y[15:6], y[4:0]};

    // bar = x*8/H_ACTIVE, done as threshold compares to avoid a divider
    always_comb begin
        bar = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if ({x, 3'b000} >= 19'(k * H_ACTIVE)) begin
                bar = 3'(k);
            end
        end
    end

    always_comb begin
        pix = 16'h0000;
        case (pat_q)
            PatBars:  pix = bar_colour(bar);
            PatCount: pix = pix_idx;
            PatRamp:  pix = x;
            default:  pix = (x[5] ^ y[5]) ? 16'hFFFF : 16'h0000;
        endcase
    end

endmodule

// File: rtl/cam_dvp_gen.sv
// DVP camera-source emulator: frame/line counters, phase FSM, byte mux, registered outputs.
module cam_dvp_gen
    import cam_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 800,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 4,
    parameter int unsigned V_BACK      = 16,
    parameter int unsigned V_FRONT     = 10
) (
    input  logic        cmos_pclk,
    input  logic        rst_133,
    input  logic        en,
    input  logic [1:0]  pattern_sel,
    output logic        cam_vsyn,
    output logic        cam_href,
    output logic [7:0]  cam_data,
    output logic [15:0] frame_cnt,
    output logic        busy
);

    localparam int unsigned LINE_CLKS = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned V_TOTAL   = VSYNC_LINES + V_BACK + V_ACTIVE + V_FRONT;

    localparam logic [15:0] HLast   = 16'(LINE_CLKS - 1);
    localparam logic [15:0] HrefEnd = 16'(2 * H_ACTIVE);
    localparam logic [15:0] VsLast  = 16'(VSYNC_LINES - 1);
    localparam logic [15:0] VbLast  = 16'(VSYNC_LINES + V_BACK - 1);
    localparam logic [15:0] VaLast  = 16'(VSYNC_LINES + V_BACK + V_ACTIVE - 1);
    localparam logic [15:0] VLast   = 16'(V_TOTAL - 1);
    localparam logic [15:0] YOff    = 16'(VSYNC_LINES + V_BACK);

    phase_e      state;
    logic [15:0] hcnt;
    logic [15:0] vcnt;
    logic [15:0] pix_idx;
    logic [1:0]  pat_q;
    logic [15:0] pix;
    logic        line_end;
    logic        href_now;

    assign line_end = (hcnt == HLast);
    assign href_now = (state == StActive) && (hcnt < HrefEnd);

    cam_pattern_pix #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pix (
        .x       ({1'b0, hcnt[15:1]}),
        .y       (vcnt - YOff),
        .pat_q   (pat_q),
        .pix_idx (pix_idx),
        .pix     (pix)
    );

    always_ff @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            state     <= StIdle;
            hcnt      <= 16'd0;
            vcnt      <= 16'd0;
            pix_idx   <= 16'd0;
            pat_q     <= PatBars;
            frame_cnt <= 16'd0;
            cam_vsyn  <= 1'b0;
            cam_href  <= 1'b0;
            cam_data  <= 8'h00;
            busy      <= 1'b0;
        end else begin
            // Outputs reflect the state before this edge, so they lag the FSM by one clock
            cam_vsyn <= (state == StVsync);
            cam_href <= href_now;
            cam_data <= href_now ? (hcnt[0] ? pix[7:0] : pix[15:8]) : 8'h00;
            busy     <= (state != StIdle);

            if (state == StIdle) begin
                if (en) begin
                    state   <= StVsync;
                    pat_q   <= pattern_sel;
                    hcnt    <= 16'd0;
                    vcnt    <= 16'd0;
                    pix_idx <= 16'd0;
                end
            end else begin
                hcnt <= line_end ? 16'd0 : hcnt + 16'd1;
                if (line_end) begin
                    vcnt <= (vcnt == VLast) ? 16'd0 : vcnt + 16'd1;
                end
                if (href_now && hcnt[0]) begin
                    pix_idx <= pix_idx + 16'd1;
                end

                case (state)
                    StVsync:  if (line_end && vcnt == VsLast) state <= StVback;
                    StVback:  if (line_end && vcnt == VbLast) state <= StActive;
                    StActive: if (line_end && vcnt == VaLast) state <= StVfront;
                    StVfront: begin
                        if (line_end && vcnt == VLast) begin
                            frame_cnt <= frame_cnt + 16'd1;
                            pix_idx   <= 16'd0;
                            pat_q     <= pattern_sel;
                            state     <= en ? StVsync : StIdle;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_dvp_gen.sv
// Randomized bench for cam_dvp_gen against a frame-timeline reference model.
module tb_cam_dvp_gen;

    localparam int unsigned HA    = 40;
    localparam int unsigned VA    = 6;
    localparam int unsigned HB    = 8;
    localparam int unsigned VS    = 2;
    localparam int unsigned VB    = 2;
    localparam int unsigned VF    = 2;
    localparam int unsigned LINE  = 2 * HA + HB;
    localparam int unsigned FRAME = (VS + VB + VA + VF) * LINE;

    logic        cmos_pclk = 1'b0;
    logic        rst_133;
    logic        en;
    logic [1:0]  pattern_sel;
    logic        cam_vsyn;
    logic        cam_href;
    logic [7:0]  cam_data;
    logic [15:0] frame_cnt;
    logic        busy;

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    logic [15:0] bar_tab [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                 16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    cam_dvp_gen #(
        .H_ACTIVE    (HA),
        .V_ACTIVE    (VA),
        .H_BLANK     (HB),
        .VSYNC_LINES (VS),
        .V_BACK      (VB),
        .V_FRONT     (VF)
    ) dut (
        .cmos_pclk   (cmos_pclk),
        .rst_133     (rst_133),
        .en          (en),
        .pattern_sel (pattern_sel),
        .cam_vsyn    (cam_vsyn),
        .cam_href    (cam_href),
        .cam_data    (cam_data),
        .frame_cnt   (frame_cnt),
        .busy        (busy)
    );

    always #5 cmos_pclk = ~cmos_pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] ref_pix(input logic [1:0] pat, input int unsigned x,
                                            input int unsigned y, input int unsigned idx);
        case (pat)
            2'd0:    return bar_tab[(x * 8) / HA];
            2'd1:    return 16'(idx % 65536);
            2'd2:    return 16'(x);
            default: return ((((x / 32) + (y / 32)) % 2) == 1) ? 16'hFFFF : 16'h0000;
        endcase
    endfunction

    // {vsyn, href, busy, data} for elapsed clock t of a running frame
    function automatic logic [10:0] exp_out(input bit run, input int unsigned t,
                                            input logic [1:0] pat);
        int unsigned line, h, la, x;
        logic [15:0] p;
        logic act;
        if (!run) return 11'd0;
        line = t / LINE;
        h    = t % LINE;
        act  = (line >= VS + VB) && (line < VS + VB + VA) && (h < 2 * HA);
        if (!act) return {line < VS, 1'b0, 1'b1, 8'h00};
        la = line - (VS + VB);
        x  = h / 2;
        p  = ref_pix(pat, x, la, la * HA + x);
        return {1'b0, 1'b1, 1'b1, (h % 2 == 1) ? p[7:0] : p[15:8]};
    endfunction

    bit          m_run;
    int unsigned m_t;
    logic [1:0]  m_pat;
    logic [15:0] m_fc;
    logic [10:0] m_out;

    always @(posedge cmos_pclk or negedge rst_133) begin
        if (!rst_133) begin
            m_run <= 1'b0;
            m_t   <= 0;
            m_pat <= 2'd0;
            m_fc  <= 16'd0;
            m_out <= 11'd0;
        end else begin
            m_out <= exp_out(m_run, m_t, m_pat);
            if (!m_run) begin
                if (en) begin
                    m_run <= 1'b1;
                    m_t   <= 0;
                    m_pat <= pattern_sel;
                end
            end else if (m_t == FRAME - 1) begin
                m_fc  <= m_fc + 16'd1;
                m_t   <= 0;
                m_pat <= pattern_sel;
                if (!en) m_run <= 1'b0;
            end else begin
                m_t <= m_t + 1;
            end
        end
    end

    always @(negedge cmos_pclk) begin
        if (chk_on) begin
            check_eq("vsyn", cam_vsyn, m_out[10]);
            check_eq("href", cam_href, m_out[9]);
            check_eq("busy", busy, m_out[8]);
            check_eq("data", cam_data, m_out[7:0]);
            check_eq("frame_cnt", frame_cnt, m_fc);
        end
    end

    initial begin
        int n;
        int m;
        rst_133     = 1'b0;
        en          = 1'b0;
        pattern_sel = 2'd0;
        repeat (3) @(negedge cmos_pclk);
        check_eq("rst_vsyn", cam_vsyn, 0);
        check_eq("rst_href", cam_href, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_fcnt", frame_cnt, 0);

        // First frame: colour bars, directed timing checks alongside the model
        chk_on  = 1'b1;
        en      = 1'b1;
        rst_133 = 1'b1;
        n = 0;
        while (!cam_vsyn && n < 20) begin @(negedge cmos_pclk); n++; end
        check_eq("vsyn_latency", n, 2);
        n = 0;
        while (cam_vsyn && n < FRAME) begin @(negedge cmos_pclk); n++; end
        check_eq("vsyn_len", n, VS * LINE);
        m = 0;
        while (!cam_href && m < FRAME) begin @(negedge cmos_pclk); m++; end
        check_eq("first_href", n + m, (VS + VB) * LINE);
        check_eq("byte0", cam_data, 8'hFF);
        @(negedge cmos_pclk);
        check_eq("byte1", cam_data, 8'hFF);
        n = 0;
        while (frame_cnt != 16'd1 && n < FRAME) begin @(negedge cmos_pclk); n++; end
        check_eq("fcnt_one", frame_cnt, 1);

        // Random patterns, frequent mid-frame sel changes, rare en drops
        for (int i = 0; i < 6 * FRAME; i++) begin
            pattern_sel = 2'($urandom);
            en          = ($urandom_range(0, 499) != 0);
            @(negedge cmos_pclk);
        end

        // Drop en during an active line: frame completes then stays idle
        en = 1'b1;
        n = 0;
        while (!cam_href && n < 2 * FRAME) begin @(negedge cmos_pclk); n++; end
        check_eq("href_seen", cam_href, 1);
        en = 1'b0;
        n = 0;
        while (busy && n < 2 * FRAME) begin @(negedge cmos_pclk); n++; end
        check_eq("busy_drop", busy, 0);
        n = 0;
        for (int i = 0; i < 2 * LINE; i++) begin
            @(negedge cmos_pclk);
            if (cam_vsyn) n++;
        end
        check_eq("idle_vsyn", n, 0);

        // Asynchronous reset in the middle of an href
        en = 1'b1;
        pattern_sel = 2'd3;
        n = 0;
        while (!cam_href && n < 2 * FRAME) begin @(negedge cmos_pclk); n++; end
        check_eq("href_pre_rst", cam_href, 1);
        #2;
        rst_133 = 1'b0;
        #1;
        check_eq("arst_vsyn", cam_vsyn, 0);
        check_eq("arst_href", cam_href, 0);
        check_eq("arst_data", cam_data, 0);
        check_eq("arst_busy", busy, 0);
        check_eq("arst_fcnt", frame_cnt, 0);
        @(negedge cmos_pclk);
        rst_133 = 1'b1;
        n = 0;
        while (!cam_vsyn && n < 20) begin @(negedge cmos_pclk); n++; end
        check_eq("vsyn_latency2", n, 2);

        for (int i = 0; i < 3 * FRAME; i++) begin
            if (($urandom & 32'h3F) == 0) pattern_sel = 2'($urandom);
            @(negedge cmos_pclk);
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
